// File: rtl/fphub_multiplier_if.sv
// -----------------------------------------------------------------------------
// fphub_multiplier_if
// Operation bus of the FPHUB multiplier. The signal set and handshake are the
// same as the FPHUB SRT divider's, so one dispatcher can drive either unit.
//
// Handshake: the master raises start with operands x/y. The unit accepts only
// while idle (computing = 0). An accepted request ends with a one-cycle finish
// pulse, and res is valid from that cycle until the next finish. A start seen
// while computing = 1 is dropped, and the master must not expect a result for it.
//
// Signals (operands/results are {sign, exp[E-1:0], mant[M-1:0]}, HUB format)
//   start      master -> slave  operation request
//   x, y       master -> slave  operands, sampled at the accepting edge only
//   res        slave  -> master result, held until the next finish
//   finish     slave  -> master one-cycle result-valid pulse
//   computing  slave  -> master high while an operation is in flight
// -----------------------------------------------------------------------------
interface fphub_multiplier_if #(
    parameter int M = 23,
    parameter int E = 8
);
    logic             start;
    logic [M+E:0]     x;
    logic [M+E:0]     y;
    logic [M+E:0]     res;
    logic             finish;
    logic             computing;

    modport master (
        output start, x, y,
        input  res, finish, computing
    );

    modport slave (
        input  start, x, y,
        output res, finish, computing
    );
endinterface

// File: rtl/fphub_multiplier.sv
// -----------------------------------------------------------------------------
// fphub_multiplier
// Sequential radix-2 shift-add floating-point multiplier for HUB operands.
// One multiplier bit is retired per cycle (LSB first). The full product is then
// normalized once, and the result is registered. HUB round-to-nearest is
// plain truncation, and the result ILSB is implicit.
//
// Ports
//   clk      rising-edge clock
//   rst_l    asynchronous active-low reset
//   mul_if   operation bus (slave side): start, x, y, res, finish, computing
//   state_o  current FSM state (0 idle, 1 multiply, 2 normalize)
//
// Latency: special operands take 1 edge. Normal operands take M+3 edges
// (M+2 shift-add cycles plus one normalize cycle).
// -----------------------------------------------------------------------------
module fphub_multiplier #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic                  clk,
    input  logic                  rst_l,
    fphub_multiplier_if.slave     mul_if,
    output logic [1:0]            state_o
);

    localparam int W  = M + E + 1;
    localparam int PW = 2 * M + 4;           // full product width
    localparam int CW = $clog2(M + 2);       // counter covers 0 .. M+1

    localparam logic signed [E+1:0] BIAS    = (E+2)'((1 << (E - 1)) - 1);
    localparam logic signed [E+1:0] EMAX    = (E+2)'((1 << E) - 1);
    localparam logic [CW-1:0]       CNT_END = CW'(M + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2
    } state_t;

    state_t               state_q;
    logic [W-1:0]         res_q;
    logic                 finish_q;
    logic                 computing_q;
    logic [PW-1:0]        p_q;           // product accumulator
    logic [PW-1:0]        mcand_q;       // Sx, shifted left to the current weight
    logic [M+1:0]         mult_q;        // Sy, shifted right so bit 0 is current
    logic [CW-1:0]        cnt_q;
    logic                 sign_q;
    logic signed [E+1:0]  esum_q;        // ex + ey - bias, before normalization

    // ---------------- operand decode ----------------
    logic          x_sign, y_sign, in_sign;
    logic [E-1:0]  x_exp, y_exp;
    logic [M-1:0]  x_mant, y_mant;
    logic          x_zero, y_zero, x_inf, y_inf;
    logic          special;
    logic [M+1:0]  sx, sy;
    logic signed [E+1:0] esum_in;
    logic [W-1:0]  special_res;

    assign x_sign  = mul_if.x[W-1];
    assign y_sign  = mul_if.y[W-1];
    assign x_exp   = mul_if.x[M+E-1:M];
    assign y_exp   = mul_if.y[M+E-1:M];
    assign x_mant  = mul_if.x[M-1:0];
    assign y_mant  = mul_if.y[M-1:0];
    assign in_sign = x_sign ^ y_sign;

    assign x_zero  = (x_exp == '0);
    assign y_zero  = (y_exp == '0);
    assign x_inf   = (x_exp == '1);
    assign y_inf   = (y_exp == '1);
    assign special = x_zero | y_zero | x_inf | y_inf;

    // HUB significand: implicit one, stored mantissa, implicit ILSB
    assign sx = {1'b1, x_mant, 1'b1};
    assign sy = {1'b1, y_mant, 1'b1};

    assign esum_in = $signed({2'b00, x_exp}) + $signed({2'b00, y_exp}) - BIAS;

    always_comb begin
        special_res = {in_sign, {E{1'b0}}, {M{1'b0}}};
        if ((x_zero && y_inf) || (x_inf && y_zero)) begin
            special_res = {1'b0, {E{1'b1}}, {M{1'b1}}};
        end else if (x_inf || y_inf) begin
            special_res = {in_sign, {E{1'b1}}, {M{1'b0}}};
        end
    end

    // ---------------- shift-add step ----------------
    logic [PW-1:0] p_d;
    assign p_d = p_q + (mult_q[0] ? mcand_q : '0);

    // ---------------- normalization ----------------
    // The product of two significands in [1,2) lies in [1,4). The top bit says
    // whether one extra right shift (and exponent increment) is needed.
    logic                norm_n;
    logic [M-1:0]        norm_mant;
    logic signed [E+1:0] e_fin;
    logic                e_ovf, e_unf;
    logic [W-1:0]        res_norm_d;

    assign norm_n    = p_q[PW-1];
    assign norm_mant = norm_n ? p_q[2*M+2:M+3] : p_q[2*M+1:M+2];
    assign e_fin     = esum_q + $signed({{(E+1){1'b0}}, norm_n});
    assign e_ovf     = (e_fin >= EMAX);
    assign e_unf     = e_fin[E+1] | (e_fin == '0);

    always_comb begin
        res_norm_d = {sign_q, e_fin[E-1:0], norm_mant};
        if (e_ovf) begin
            res_norm_d = {sign_q, {E{1'b1}}, {M{1'b0}}};
        end else if (e_unf) begin
            res_norm_d = {sign_q, {E{1'b0}}, {M{1'b0}}};
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= S_IDLE;
            res_q       <= '0;
            finish_q    <= 1'b0;
            computing_q <= 1'b0;
            p_q         <= '0;
            mcand_q     <= '0;
            mult_q      <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            esum_q      <= '0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mul_if.start) begin
                        if (special) begin
                            res_q    <= special_res;
                            finish_q <= 1'b1;
                        end else begin
                            mcand_q     <= {{(M+2){1'b0}}, sx};
                            mult_q      <= sy;
                            sign_q      <= in_sign;
                            esum_q      <= esum_in;
                            p_q         <= '0;
                            cnt_q       <= '0;
                            computing_q <= 1'b1;
                            state_q     <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    p_q     <= p_d;
                    mcand_q <= mcand_q << 1;
                    mult_q  <= mult_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CNT_END) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    res_q       <= res_norm_d;
                    finish_q    <= 1'b1;
                    computing_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_if.res       = res_q;
    assign mul_if.finish    = finish_q;
    assign mul_if.computing = computing_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_fphub_multiplier.sv
module tb_fphub_multiplier;

    localparam int M = 23;
    localparam int E = 8;
    localparam int NORM_LAT = M + 3;   // edges from accept to finish
    localparam logic [31:0] JUNK_X = 32'h7F800000;
    localparam logic [31:0] JUNK_Y = 32'h00000000;

    logic       clk;
    logic       rst_l;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];

    fphub_multiplier_if #(.M(M), .E(E)) mif ();

    fphub_multiplier #(.M(M), .E(E)) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .mul_if  (mif),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mif.start = 1'b1;
        mif.x     = a;
        mif.y     = b;
        @(negedge clk);
        mif.start = 1'b0;
        mif.x     = JUNK_X;   // operands must already be latched
        mif.y     = JUNK_Y;
    endtask

    // Called at the sample just after the accepting edge (edge count 0).
    task automatic wait_finish(output int lat, output int comp_cnt, output logic [31:0] r);
        lat      = 0;
        comp_cnt = 0;
        while (mif.finish !== 1'b1 && lat < 100) begin
            if (mif.computing === 1'b1) comp_cnt++;
            @(negedge clk);
            lat++;
        end
        r = mif.res;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_l     = 1'b0;
        mif.start = 1'b0;
        mif.x     = '0;
        mif.y     = '0;
        repeat (3) @(negedge clk);
        checks++; if (mif.res !== 32'h0) begin errors++; $display("FAIL reset_res got=%h exp=%h", mif.res, 32'h0); end
        checks++; if (mif.finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", mif.finish); end
        checks++; if (mif.computing !== 1'b0) begin errors++; $display("FAIL reset_computing got=%b exp=0", mif.computing); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unit();
        int lat, cc;
        logic [31:0] r;
        start_op(32'h3F800000, 32'h3F800000);
        wait_finish(lat, cc, r);
        checks++; if (r !== 32'h3F800001) begin errors++; $display("FAIL unit_res got=%h exp=%h", r, 32'h3F800001); end
        checks++; if (lat !== NORM_LAT) begin errors++; $display("FAIL unit_latency got=%0d exp=%0d", lat, NORM_LAT); end
        checks++; if (cc !== NORM_LAT) begin errors++; $display("FAIL unit_computing_cycles got=%0d exp=%0d", cc, NORM_LAT); end
        checks++; if (mif.computing !== 1'b0) begin errors++; $display("FAIL unit_computing_at_finish got=%b exp=0", mif.computing); end
        @(negedge clk);
        checks++; if (mif.finish !== 1'b0) begin errors++; $display("FAIL unit_finish_width got=%b exp=0", mif.finish); end
    endtask

    task automatic test_normalize();
        int lat, cc;
        logic [31:0] r;
        start_op(32'h40000000, 32'h40400000);
        wait_finish(lat, cc, r);
        checks++; if (r !== 32'h40C00001) begin errors++; $display("FAIL nonorm_res got=%h exp=%h", r, 32'h40C00001); end
        checks++; if (lat !== NORM_LAT) begin errors++; $display("FAIL nonorm_latency got=%0d exp=%0d", lat, NORM_LAT); end
        start_op(32'h3FC00000, 32'h3FC00000);
        wait_finish(lat, cc, r);
        checks++; if (r !== 32'h40100000) begin errors++; $display("FAIL norm_res got=%h exp=%h", r, 32'h40100000); end
        checks++; if (lat !== NORM_LAT) begin errors++; $display("FAIL norm_latency got=%0d exp=%0d", lat, NORM_LAT); end
    endtask

    // Runs right after test_normalize, so the held result is 0x40100000.
    task automatic test_ignore_start();
        int j;
        int extra;
        start_op(32'h40000000, 32'h40400000);
        j = 0;
        while (mif.finish !== 1'b1 && j < 100) begin
            if (j == 5) begin
                mif.start = 1'b1;          // special operands: would finish at once
                mif.x     = 32'h7F800000;
                mif.y     = 32'hC0000000;
            end else begin
                mif.start = 1'b0;
                mif.x     = JUNK_X;
                mif.y     = JUNK_Y;
            end
            if (j == 8) begin
                checks++; if (mif.res !== 32'h40100000) begin errors++; $display("FAIL ignore_res_held got=%h exp=%h", mif.res, 32'h40100000); end
                checks++; if (mif.computing !== 1'b1) begin errors++; $display("FAIL ignore_computing got=%b exp=1", mif.computing); end
            end
            @(negedge clk);
            j++;
        end
        mif.start = 1'b0;
        checks++; if (j !== NORM_LAT) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", j, NORM_LAT); end
        checks++; if (mif.res !== 32'h40C00001) begin errors++; $display("FAIL ignore_res got=%h exp=%h", mif.res, 32'h40C00001); end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (mif.finish === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra_finish got=%0d exp=0", extra); end
    endtask

    task automatic test_special();
        logic [31:0] xs [4] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h00000000};
        logic [31:0] ys [4] = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'h7F800000};
        logic [31:0] es [4] = '{32'h00000000, 32'h80000000, 32'hFF800000, 32'h7FFFFFFF};
        int lat, cc;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            start_op(xs[i], ys[i]);
            wait_finish(lat, cc, r);
            checks++; if (r !== es[i]) begin errors++; $display("FAIL special%0d_res got=%h exp=%h", i, r, es[i]); end
            checks++; if (lat !== 0) begin errors++; $display("FAIL special%0d_latency got=%0d exp=0", i, lat); end
            checks++; if (cc !== 0 || mif.computing !== 1'b0) begin errors++; $display("FAIL special%0d_computing got=%0d exp=0", i, cc); end
        end
    endtask

    task automatic test_range();
        int lat, cc;
        logic [31:0] r;
        start_op(32'h7F000000, 32'h7F000000);
        wait_finish(lat, cc, r);
        checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL overflow_res got=%h exp=%h", r, 32'h7F800000); end
        checks++; if (lat !== NORM_LAT) begin errors++; $display("FAIL overflow_latency got=%0d exp=%0d", lat, NORM_LAT); end
        start_op(32'h01000000, 32'h01000000);
        wait_finish(lat, cc, r);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL underflow_res got=%h exp=%h", r, 32'h0); end
        checks++; if (lat !== NORM_LAT) begin errors++; $display("FAIL underflow_latency got=%0d exp=%0d", lat, NORM_LAT); end
    endtask

    // start held high; operands change every cycle. Only those present at
    // edges 0, 27 and 54 may be used.
    task automatic test_back_to_back();
        logic [31:0] ax [3] = '{32'h3F800000, 32'h40000000, 32'h3FC00000};
        logic [31:0] ay [3] = '{32'h3F800000, 32'h40400000, 32'h3FC00000};
        logic [31:0] ae [3] = '{32'h3F800001, 32'h40C00001, 32'h40100000};
        logic [31:0] want;
        int nfin;
        nfin = 0;
        exp_q.delete();
        @(negedge clk);
        for (int c = 0; c <= 80; c++) begin
            mif.start = 1'b1;
            if (c % 27 == 0) begin
                mif.x = ax[c / 27];
                mif.y = ay[c / 27];
                exp_q.push_back(ae[c / 27]);
            end else begin
                mif.x = (c % 2 == 0) ? JUNK_X : 32'h40400000;
                mif.y = (c % 2 == 0) ? JUNK_Y : 32'hBF800000;
            end
            @(negedge clk);
            if (mif.finish === 1'b1) begin
                nfin++;
                checks++; if (c % 27 != 26) begin errors++; $display("FAIL b2b_finish_cycle got=%0d exp=%0d", c, (c / 27) * 27 + 26); end
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    checks++; if (mif.res !== want) begin errors++; $display("FAIL b2b_res got=%h exp=%h", mif.res, want); end
                end
            end
        end
        mif.start = 1'b0;
        mif.x     = JUNK_X;
        mif.y     = JUNK_Y;
        checks++; if (nfin !== 3) begin errors++; $display("FAIL b2b_finish_count got=%0d exp=3", nfin); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending got=%0d exp=0", exp_q.size()); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, cc, nfin;
        logic [31:0] r;
        start_op(32'h40000000, 32'h40400000);
        repeat (10) @(negedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        checks++; if (mif.res !== 32'h0) begin errors++; $display("FAIL abort_res got=%h exp=%h", mif.res, 32'h0); end
        checks++; if (mif.finish !== 1'b0) begin errors++; $display("FAIL abort_finish got=%b exp=0", mif.finish); end
        checks++; if (mif.computing !== 1'b0) begin errors++; $display("FAIL abort_computing got=%b exp=0", mif.computing); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", state_o); end
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        nfin = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.finish === 1'b1 || mif.computing === 1'b1) nfin++;
        end
        checks++; if (nfin !== 0) begin errors++; $display("FAIL abort_no_finish got=%0d exp=0", nfin); end
        start_op(32'h3FC00000, 32'h3FC00000);
        wait_finish(lat, cc, r);
        checks++; if (r !== 32'h40100000) begin errors++; $display("FAIL abort_restart_res got=%h exp=%h", r, 32'h40100000); end
        checks++; if (lat !== NORM_LAT) begin errors++; $display("FAIL abort_restart_latency got=%0d exp=%0d", lat, NORM_LAT); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_unit();
        test_normalize();
        test_ignore_start();
        test_special();
        test_range();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
